dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 64-word data memory used in the M stage.
- Port 0 is the pipeline M-stage load/store. Port 1 is a loader/debug master that preloads or inspects memory.
- Serialises both ports onto the memory's one combinational-read, synchronous-write interface, stalls the pipeline on conflicts, bounds port 1 starvation, and checks alignment and range.

Parameters:
- ADDR_W, 32, byte address width of both request ports and the memory port.
- DATA_W, 32, data word width.
- MEM_WORDS, 64, number of memory words; addresses at or above MEM_WORDS*4 are out of range.
- MAX_WAIT, 4, consecutive cycles port 1 may lose arbitration before it is force-granted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  M-stage request valid
- p0_we  in  1  M-stage write enable (1 = store, 0 = load)
- p0_addr  in  ADDR_W  M-stage byte address
- p0_wdata  in  DATA_W  M-stage store data
- p0_stall  out  1  high while p0_req is held and not granted (combinational)
- p0_rvalid  out  1  port 0 response valid, registered
- p0_rdata  out  DATA_W  port 0 load data, registered
- p0_err  out  1  port 0 error, valid with p0_rvalid
- p1_req  in  1  loader request; held until p1_gnt
- p1_we  in  1  loader write enable
- p1_addr  in  ADDR_W  loader byte address
- p1_wdata  in  DATA_W  loader write data
- p1_gnt  out  1  loader request accepted this cycle (combinational)
- p1_rvalid  out  1  port 1 response valid, registered
- p1_rdata  out  DATA_W  port 1 load data, registered
- p1_err  out  1  port 1 error, valid with p1_rvalid
- mem_write  out  1  write strobe to the memory
- mem_address  out  ADDR_W  byte address to the memory
- mem_write_data  out  DATA_W  write data to the memory
- mem_read_data  in  DATA_W  combinational read data from the memory

Behaviour:
- Reset values:
  - All registered outputs are 0.
  - Wait counter is 0.
  - FSM is in ARB.
- One memory access per cycle.
- A grant is issued in cycle N. The response (rvalid, rdata, err) is registered at the clk edge ending cycle N and is visible in cycle N+1, as a one-cycle pulse.
- FSM states:
  - ARB: normal operation; port 0 has fixed priority.
  - FORCE1: entered when the wait counter reaches MAX_WAIT while p1_req is high. In FORCE1, port 1 is granted unconditionally for exactly one cycle, p0_stall = p0_req, then the FSM returns to ARB.
- Grant rules in ARB:
  - p0_req alone: port 0 granted.
  - p1_req alone: port 1 granted.
  - Both: port 0 granted and the wait counter increments.
- Wait counter:
  - Clears whenever port 1 is granted or p1_req is low.
  - Saturates at MAX_WAIT.
- Error checks:
  - Misaligned (addr[1:0] != 0) or out of range (addr >= MEM_WORDS*4): the request is still granted and consumes its slot.
  - mem_write is forced 0; err=1 and rdata=0 in the response.
- Memory mux:
  - mem_address and mem_write_data carry the granted port's values.
  - mem_write = granted port's we & grant & ~err.
  - When nothing is granted, mem_address = 0 and mem_write = 0.
- Store response: rvalid=1, rdata=0.
- Same-cycle read/write: a load granted in the cycle after a store to the same word returns the new data, because the write completes at the edge.
- p0_stall = p0_req & ~p0_granted. The pipeline must hold p0_* stable while stalled.
- Reset mid-operation: pending responses are dropped, FORCE1 is abandoned, and no mem_write occurs in the reset cycle.
- p1 request change before grant: if p1_addr/p1_we change while p1_req is held, the values sampled in the grant cycle are used.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_conflicts (16 bits; increments each cycle both ports request) and perf_forced (16 bits; increments on each FORCE1 entry).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - Constants MEM_WORDS_DEFAULT=64 and WORD_BYTES=4.
  - FSM state encoding ARB=1'b0, FORCE1=1'b1.
  - Function addr_ok(addr) returning the alignment and range check.
- Sub-module dmem_req_check: per-port combinational alignment/range check, instanced twice.
- The arbitration FSM, mux and response registers stay in the top level.

Test Plan:
- p0 store then load: p0 store addr 0x10 data 0xDEADBEEF, then load 0x10 -> mem_write=1 for one cycle; next p0 response p0_rdata=0xDEADBEEF, p0_err=0, p0_stall=0 throughout.
- Continuous conflict: p0_req and p1_req both held continuously -> p0 granted 4 cycles, 5th cycle FORCE1 (p1_gnt=1, p0_stall=1), then the pattern repeats.
- Misaligned store: p1 store to addr 0x06 -> p1_gnt=1, mem_write=0, next cycle p1_rvalid=1, p1_err=1, memory unchanged.
- Out of range: p0 load addr 0x100 with MEM_WORDS=64 -> p0_err=1, p0_rdata=0.
- Reset during FORCE1: assert reset during FORCE1 -> next cycle all rvalid=0, wait counter=0, p1_gnt follows ARB priority.
- Perf counters (DMEM_ARB_PERF_EN defined): 10 conflict cycles -> perf_conflicts=10, perf_forced=2.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data memory arbiter: sizes, FSM encoding
// and the address legality check used by both request ports.
package dmem_pkg;

   localparam int unsigned MEM_WORDS_DEFAULT = 64;
   localparam int unsigned WORD_BYTES        = 4;

   typedef enum logic {
      ARB    = 1'b0,
      FORCE1 = 1'b1
   } arb_state_e;

   // Word-aligned and inside the memory; callers zero-extend narrower addresses.
   function automatic logic addr_ok(input logic [63:0] addr,
                                    input int unsigned mem_words = MEM_WORDS_DEFAULT);
      logic [63:0] limit;
      limit = 64'(mem_words) * 64'(WORD_BYTES);
      return (addr[1:0] == 2'b00) && (addr < limit);
   endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Per-port request legality check: flags misaligned or out-of-range addresses.
module dmem_req_check
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              err
);

   always_comb begin
      err = ~addr_ok(64'(addr), MEM_WORDS);
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port M-stage data memory.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter int unsigned MAX_WAIT  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_stall,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0]       perf_conflicts,
   output logic [15:0]       perf_forced
`endif
);

   localparam int unsigned    CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              gnt0, gnt1;
   logic              err0, err1;

   logic              p0_rvalid_q, p0_rvalid_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic              p0_err_q, p0_err_d;
   logic              p1_rvalid_q, p1_rvalid_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
   logic              p1_err_q, p1_err_d;

   dmem_req_check #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_chk0 (
      .addr (p0_addr),
      .err  (err0)
   );

   dmem_req_check #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_chk1 (
      .addr (p1_addr),
      .err  (err1)
   );

   // Nothing is granted while reset is held, so no write can slip through.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (state_q == FORCE1) begin
            gnt1 = p1_req;
         end else begin
            gnt0 = p0_req;
            gnt1 = p1_req & ~p0_req;
         end
      end
   end

   assign p0_stall = p0_req & ~gnt0;
   assign p1_gnt   = gnt1;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (state_q == FORCE1) begin
         state_d = ARB;
         wait_d  = '0;
      end else if (!p1_req || gnt1) begin
         wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + CNT_W'(1);
      end
      // Force on the edge where the count saturates so port 1 wins the very next slot.
      if (state_q == ARB && p1_req && wait_d == WAIT_MAX) begin
         state_d = FORCE1;
      end
   end

   always_comb begin
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (gnt0) begin
         mem_write      = p0_we & ~err0;
         mem_address    = p0_addr;
         mem_write_data = p0_wdata;
      end else if (gnt1) begin
         mem_write      = p1_we & ~err1;
         mem_address    = p1_addr;
         mem_write_data = p1_wdata;
      end
   end

   // Stores and errored requests respond with zero data.
   always_comb begin
      p0_rvalid_d = gnt0;
      p0_err_d    = gnt0 & err0;
      p0_rdata_d  = (gnt0 & ~p0_we & ~err0) ? mem_read_data : '0;
      p1_rvalid_d = gnt1;
      p1_err_d    = gnt1 & err1;
      p1_rdata_d  = (gnt1 & ~p1_we & ~err1) ? mem_read_data : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB;
         wait_q      <= '0;
         p0_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p0_err_q    <= 1'b0;
         p1_rvalid_q <= 1'b0;
         p1_rdata_q  <= '0;
         p1_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         p0_rvalid_q <= p0_rvalid_d;
         p0_rdata_q  <= p0_rdata_d;
         p0_err_q    <= p0_err_d;
         p1_rvalid_q <= p1_rvalid_d;
         p1_rdata_q  <= p1_rdata_d;
         p1_err_q    <= p1_err_d;
      end
   end

   assign p0_rvalid = p0_rvalid_q;
   assign p0_rdata  = p0_rdata_q;
   assign p0_err    = p0_err_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p1_rdata  = p1_rdata_q;
   assign p1_err    = p1_err_q;

`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_conf_q, perf_conf_d;
   logic [15:0] perf_forced_q, perf_forced_d;

   always_comb begin
      perf_conf_d   = perf_conf_q;
      perf_forced_d = perf_forced_q;
      if (p0_req && p1_req && perf_conf_q != 16'hFFFF) begin
         perf_conf_d = perf_conf_q + 16'd1;
      end
      if (state_q == ARB && state_d == FORCE1 && perf_forced_q != 16'hFFFF) begin
         perf_forced_d = perf_forced_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_conf_q   <= '0;
         perf_forced_q <= '0;
      end else begin
         perf_conf_q   <= perf_conf_d;
         perf_forced_q <= perf_forced_d;
      end
   end

   assign perf_conflicts = perf_conf_q;
   assign perf_forced    = perf_forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: responses are queued as expected at issue
// time and checked by an independent negedge monitor against a memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0;
   logic        p0_stall, p0_rvalid, p0_err;
   logic [31:0] p0_rdata;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = '0, p1_wdata = '0;
   logic        p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p1_rdata;
   logic        mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_conflicts, perf_forced;
`endif

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .p0_req         (p0_req),
      .p0_we          (p0_we),
      .p0_addr        (p0_addr),
      .p0_wdata       (p0_wdata),
      .p0_stall       (p0_stall),
      .p0_rvalid      (p0_rvalid),
      .p0_rdata       (p0_rdata),
      .p0_err         (p0_err),
      .p1_req         (p1_req),
      .p1_we          (p1_we),
      .p1_addr        (p1_addr),
      .p1_wdata       (p1_wdata),
      .p1_gnt         (p1_gnt),
      .p1_rvalid      (p1_rvalid),
      .p1_rdata       (p1_rdata),
      .p1_err         (p1_err),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
`ifdef DMEM_ARB_PERF_EN
      .perf_conflicts (perf_conflicts),
      .perf_forced    (perf_forced),
`endif
      .mem_read_data  (mem_read_data)
   );

   // Memory model: combinational read, write at the clock edge.
   logic [31:0] mem [0:63];
   assign mem_read_data = mem[mem_address[7:2]];
   always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   logic        chk = 1'b0, chk_perf = 1'b0, done = 1'b0;
   logic        x_stall = 1'b0, x_gnt1 = 1'b0, x_mw = 1'b0;
   int          total = 0, bad = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: sole owner of the pass/fail counters.
   always @(negedge clk) begin
      logic ev;
      if (chk) begin
         cmp("p0_stall", 32'(p0_stall), 32'(x_stall));
         cmp("p1_gnt", 32'(p1_gnt), 32'(x_gnt1));
         cmp("mem_write", 32'(mem_write), 32'(x_mw));
      end
      ev = (sb0.size() > 0) && (sb0[0].due == cyc);
      cmp("p0_rvalid", 32'(p0_rvalid), 32'(ev));
      if (sb0.size() > 0 && sb0[0].due <= cyc) begin
         if (p0_rvalid) begin
            cmp("p0_rdata", p0_rdata, sb0[0].d);
            cmp("p0_err", 32'(p0_err), 32'(sb0[0].e));
         end
         void'(sb0.pop_front());
      end
      ev = (sb1.size() > 0) && (sb1[0].due == cyc);
      cmp("p1_rvalid", 32'(p1_rvalid), 32'(ev));
      if (sb1.size() > 0 && sb1[0].due <= cyc) begin
         if (p1_rvalid) begin
            cmp("p1_rdata", p1_rdata, sb1[0].d);
            cmp("p1_err", 32'(p1_err), 32'(sb1[0].e));
         end
         void'(sb1.pop_front());
      end
`ifdef DMEM_ARB_PERF_EN
      if (chk_perf) begin
         cmp("perf_conflicts", 32'(perf_conflicts), 32'd10);
         cmp("perf_forced", 32'(perf_forced), 32'd2);
      end
`endif
      if (done) begin
         cmp("sb0_drained", 32'(sb0.size()), 32'd0);
         cmp("sb1_drained", 32'(sb1.size()), 32'd0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   // One cycle of stimulus plus the expectations it implies.
   task automatic step(input logic r,
                       input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic xs, input logic xg, input logic xm,
                       input logic v0, input logic [31:0] rd0, input logic e0,
                       input logic v1, input logic [31:0] rd1, input logic e1);
      @(posedge clk);
      #1;
      reset = r;
      p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
      x_stall = xs; x_gnt1 = xg; x_mw = xm;
      chk = 1'b1;
      if (v0) sb0.push_back('{rd0, e0, cyc + 1});
      if (v1) sb1.push_back('{rd1, e1, cyc + 1});
   endtask

   // Both ports requesting continuously; every fifth cycle is the forced port-1 slot.
   task automatic conflict(input logic f);
      step(0, 1,0,32'h10,0, 1,0,32'h20,0, f,f,0, !f,32'hDEADBEEF,0, f,32'h11111111,0);
   endtask

   initial begin
      step(1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      step(1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      step(0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,1, 1,0,0, 0,0,0);
      step(0, 1,0,32'h10,0, 0,0,0,0, 0,0,0, 1,32'hDEADBEEF,0, 0,0,0);
      step(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      step(0, 0,0,0,0, 1,1,32'h04,32'hA5A5A5A5, 0,1,1, 0,0,0, 1,0,0);
      step(0, 0,0,0,0, 1,1,32'h06,32'h12345678, 0,1,0, 0,0,0, 1,0,1);
      step(0, 0,0,0,0, 1,0,32'h04,0, 0,1,0, 0,0,0, 1,32'hA5A5A5A5,0);
      step(0, 1,0,32'h100,0, 0,0,0,0, 0,0,0, 1,0,1, 0,0,0);
      step(0, 1,0,32'h11,0, 0,0,0,0, 0,0,0, 1,0,1, 0,0,0);
      step(0, 1,1,32'hFC,32'hCAFEF00D, 0,0,0,0, 0,0,1, 1,0,0, 0,0,0);
      step(0, 0,0,0,0, 1,0,32'hFC,0, 0,1,0, 0,0,0, 1,32'hCAFEF00D,0);
      step(0, 0,0,0,0, 1,1,32'h20,32'h11111111, 0,1,1, 0,0,0, 1,0,0);
      for (int i = 1; i <= 14; i++) conflict(i % 5 == 0);
      // Reset lands in the forced slot: nothing is granted, port 0 sees a stall.
      step(1, 1,0,32'h10,0, 1,0,32'h20,0, 1,0,0, 0,0,0, 0,0,0);
      for (int j = 1; j <= 10; j++) conflict(j % 5 == 0);
      step(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      chk_perf = 1'b1;
      step(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      chk_perf = 1'b0;
      step(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      done = 1'b1;
   end

endmodule
